// File: rtl/wave_voice_scheduler.sv
// wave_voice_scheduler: time-multiplexes NUM_VOICES phase accumulators onto one
// shared waveform generator and mixes the returned samples into a saturated sum.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_we/voice/inc/en      per-voice increment/enable write (accepted in any state)
//   sample_tick              request one mixing round
//   gen_valid, gen_phase     issue strobe and 12-bit phase to the generator
//   gen_wave, gen_out_valid  signed 21-bit generator sample return
//   mix_out, mix_valid       saturated 21-bit mix and its one-cycle strobe
//   busy                     round in progress
//   tick_missed              one-cycle pulse when a tick arrives while busy
//
// GEN_LATENCY must be at least 1.
module wave_voice_scheduler #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned GEN_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [ACC_WIDTH-1:0]          cfg_inc,
  input  logic                          cfg_en,
  input  logic                          sample_tick,
  output logic                          gen_valid,
  output logic [11:0]                   gen_phase,
  input  logic [20:0]                   gen_wave,
  input  logic                          gen_out_valid,
  output logic [20:0]                   mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          tick_missed
);

  localparam int unsigned SLOT_W = $clog2(NUM_VOICES);
  localparam int unsigned SUM_W  = 21 + SLOT_W;
  localparam int unsigned CNT_W  = (GEN_LATENCY > 2) ? $clog2(GEN_LATENCY) : 1;

  localparam logic [SLOT_W-1:0]       LAST_SLOT  = SLOT_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0]        LAST_DRAIN = CNT_W'(GEN_LATENCY - 1);
  localparam logic signed [SUM_W-1:0] MIX_MAX    = SUM_W'(32'sd1048575);
  localparam logic signed [SUM_W-1:0] MIX_MIN    = SUM_W'(-32'sd1048576);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [SLOT_W-1:0]       slot;
  logic [CNT_W-1:0]        drain_cnt;
  logic signed [SUM_W-1:0] sum;

  logic [ACC_WIDTH-1:0]    acc [NUM_VOICES];
  logic [ACC_WIDTH-1:0]    inc [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en;

  logic                    issue_now;
  logic [SLOT_W-1:0]       issue_slot;
  logic signed [SUM_W-1:0] wave_ext;
  logic signed [SUM_W-1:0] sum_next;
  logic [20:0]             mix_clamped;

  // Slot whose registered gen_valid/gen_phase become visible in the next cycle.
  // The accumulator advances on the same edge that launches its phase.
  always_comb begin
    issue_now  = 1'b0;
    issue_slot = '0;
    if (state == IDLE && sample_tick) begin
      issue_now = 1'b1;
    end else if (state == ISSUE && slot != LAST_SLOT) begin
      issue_now  = 1'b1;
      issue_slot = slot + SLOT_W'(1);
    end
  end

  // Running sum including this cycle's sample, and its saturated 21-bit form.
  always_comb begin
    wave_ext = SUM_W'(signed'(gen_wave));
    sum_next = sum;
    if ((state inside {ISSUE, DRAIN}) && gen_out_valid) begin
      sum_next = sum + wave_ext;
    end
    if (sum_next > MIX_MAX) begin
      mix_clamped = 21'h0FFFFF;
    end else if (sum_next < MIX_MIN) begin
      mix_clamped = 21'h100000;
    end else begin
      mix_clamped = sum_next[20:0];
    end
  end

  // Round sequencer, voice state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      drain_cnt   <= '0;
      sum         <= '0;
      en          <= '0;
      gen_valid   <= 1'b0;
      gen_phase   <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      busy        <= 1'b0;
      tick_missed <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        acc[v] <= '0;
        inc[v] <= '0;
      end
    end else begin
      gen_valid   <= 1'b0;
      gen_phase   <= '0;
      mix_valid   <= 1'b0;
      tick_missed <= sample_tick && busy;
      sum         <= sum_next;

      if (issue_now && en[issue_slot]) begin
        gen_valid <= 1'b1;
        gen_phase <= acc[issue_slot][ACC_WIDTH-1 -: 12];
      end

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ISSUE;
            slot  <= '0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (slot == LAST_SLOT) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state     <= DONE;
            mix_out   <= mix_clamped;
            mix_valid <= 1'b1;
            sum       <= '0;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Config write follows the increment so a clear beats the advance.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (issue_now && issue_slot == SLOT_W'(v) && en[v]) begin
          acc[v] <= acc[v] + inc[v];
        end
        if (cfg_we && cfg_voice == SLOT_W'(v)) begin
          inc[v] <= cfg_inc;
          en[v]  <= cfg_en;
          if (!cfg_en) begin
            acc[v] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/wave_voice_scheduler.md
WAVE_VOICE_SCHEDULER -- requirements
Module: wave_voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of time-multiplexed voices (power of two, 2..8).
REQ-002 SHALL have parameter ACC_WIDTH, default 24, per-voice phase accumulator width.
REQ-003 SHALL have parameter GEN_LATENCY, default 2, cycles from gen_valid to gen_out_valid of the shared waveform generator.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_we  input  1  config write strobe.
REQ-007 cfg_voice  input  log2(NUM_VOICES)  voice index written.
REQ-008 cfg_inc  input  ACC_WIDTH  phase increment per sample round.
REQ-009 cfg_en  input  1  voice enable.
REQ-010 sample_tick  input  1  request one mixing round.
REQ-011 gen_valid  output  1  issue strobe to generator (its in_valid).
REQ-012 gen_phase  output  12  phase to generator.
REQ-013 gen_wave  input  21  signed generator sample.
REQ-014 gen_out_valid  input  1  generator sample valid.
REQ-015 mix_out  output  21  signed saturated sum of voices.
REQ-016 mix_valid  output  1  one-cycle pulse, mix_out valid.
REQ-017 busy  output  1  round in progress.
REQ-018 tick_missed  output  1  one-cycle pulse, a tick was dropped.

Function
REQ-019 SHALL hold per voice: acc (ACC_WIDTH), inc (ACC_WIDTH), en (1).
REQ-020 FSM states IDLE, ISSUE, DRAIN, DONE; all outputs registered.
REQ-021 IDLE: sample_tick=1 -> ISSUE, slot index 0; otherwise stay.
REQ-022 ISSUE: exactly one cycle per slot 0..NUM_VOICES-1 regardless of enables; after last slot -> DRAIN.
REQ-023 ISSUE slot i, en[i]=1: gen_valid=1, gen_phase=acc[i][ACC_WIDTH-1:ACC_WIDTH-12], acc[i] <= acc[i]+inc[i] modulo 2^ACC_WIDTH (wrap, no flag).
REQ-024 ISSUE slot i, en[i]=0: gen_valid=0, gen_phase=0, acc[i] unchanged.
REQ-025 DRAIN lasts exactly GEN_LATENCY cycles, then -> DONE; DONE lasts one cycle, then -> IDLE.
REQ-026 Timing, defaults, tick in cycle 0: gen_valid slots in cycles 1..4, DRAIN 5..6, mix_valid=1 and DONE in cycle 7, IDLE in cycle 8; busy=1 cycles 1..7.
REQ-027 Accumulator sum SHALL be signed, 21+log2(NUM_VOICES) bits; gen_wave sign-extended and added on every gen_out_valid=1 in ISSUE or DRAIN; gen_out_valid in IDLE/DONE ignored.
REQ-028 Entering DONE: mix_out <= sum clamped to [-2^20, 2^20-1]; sum cleared to 0.
REQ-029 mix_out SHALL hold its value until the next DONE.
REQ-030 All voices disabled: round still runs full length; mix_out=0, mix_valid pulses.
REQ-031 sample_tick while busy=1: dropped; tick_missed=1 next cycle; round unaffected.
REQ-032 cfg_we=1: inc[cfg_voice] <= cfg_inc, en[cfg_voice] <= cfg_en; if cfg_en=0, acc[cfg_voice] <= 0.
REQ-033 cfg write to the voice issued the same cycle: issue uses pre-write acc/inc/en; written inc/en win; acc clear (REQ-032) wins over increment.
REQ-034 cfg writes SHALL be accepted in every state without stalling.

Reset
REQ-035 rst=1 SHALL immediately force: state IDLE, slot 0, all acc/inc/en 0, sum 0, gen_valid 0, gen_phase 0, mix_out 0, mix_valid 0, busy 0, tick_missed 0.
REQ-036 rst mid-round SHALL abandon the round with no mix_valid; first tick after release starts a fresh round.

Verification
REQ-037 Voice 0 inc=0x100000 en, others off, generator model (phase<=2048 -> 0x010000, else 0x1F0000), ticks every 8 cycles -> gen_phase 0x000,0x100,...,0xF00,0x000; mix_out 0x010000 for first 9 rounds, 0x1F0000 for next 7.
REQ-038 All 4 voices enabled, acc=0, tick cycle 0 -> gen_valid cycles 1..4 phase 0, mix_valid cycle 7 only, mix_out=0x040000.
REQ-039 Generator model returning 0x0FFFFF for 4 voices -> mix_out=0x0FFFFF; returning 0x100000 for 4 voices -> mix_out=0x100000 (saturated both ways).
REQ-040 Tick in cycle 0 and cycle 3 -> one round, tick_missed=1 in cycle 4, one mix_valid in cycle 7.
REQ-041 cfg write voice 2 cfg_en=0 in same cycle as its slot -> phase issued from old acc, acc[2]=0 afterward, voice 2 silent next round.
REQ-042 rst asserted in cycle 5 of a round -> all outputs 0 immediately, no mix_valid; tick after release -> normal round with acc restarted from 0.
